// File: rtl/lsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg : shared encodings and helpers for the load/store unit
// Rev 1.0
// ----------------------------------------------------------------------------
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 9;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } lsu_state_t;

  // Size code 2'b11 behaves as a word everywhere, so only bit 1 matters here.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (is_word(size)) begin
      bad = (offset != 2'b00);
    end else if (size == SZ_HALF) begin
      bad = offset[0];
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_align : little-endian lane extract/extend for loads, lane merge for stores
// Rev 1.0
// ----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;

  assign w_shamt     = {offset_i, 3'b000};
  assign w_shifted   = rdata_i >> w_shamt;
  assign w_byte_mask = 32'h0000_00FF << w_shamt;
  assign w_half_mask = 32'h0000_FFFF << w_shamt;

  always_comb begin
    load_data_o  = rdata_i;
    merge_data_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_data_o  = {{24{signed_i & w_shifted[7]}}, w_shifted[7:0]};
        merge_data_o = (rdata_i & ~w_byte_mask) | ({24'h0, wdata_i[7:0]} << w_shamt);
      end
      SZ_HALF: begin
        load_data_o  = {{16{signed_i & w_shifted[15]}}, w_shifted[15:0]};
        merge_data_o = (rdata_i & ~w_half_mask) | ({16'h0, wdata_i[15:0]} << w_shamt);
      end
      default: begin
        load_data_o  = rdata_i;
        merge_data_o = wdata_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit : memory-stage LSU, one request at a time, RMW sub-word stores
// Rev 1.0
// ----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [4:0]        resp_rd,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_rw
);

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wword_q, wword_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [4:0]        resp_rd_q, resp_rd_d;

  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  lsu_align u_align (
    .rdata_i      (mem_read_data),
    .wdata_i      (wdata_q),
    .offset_i     (off_q),
    .size_i       (size_q),
    .signed_i     (signed_q),
    .load_data_o  (w_load_data),
    .merge_data_o (w_merge_data)
  );

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    signed_d  = signed_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    wword_d   = wword_q;
    rdata_d   = rdata_q;
    resp_rd_d = resp_rd_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          off_d    = req_addr[1:0];
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          raddr_d  = req_addr[ADDR_W+1:2];
          waddr_d  = req_addr[ADDR_W+1:2];
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d = ERR;
          end else if (req_write && is_word(req_size)) begin
            wword_d = req_wdata;
            state_d = WRITE;
          end else begin
            // Loads and sub-word stores both need the current memory word.
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          wword_d = w_merge_data;
          state_d = WRITE;
        end else begin
          rdata_d   = w_load_data;
          resp_rd_d = rd_q;
          state_d   = RESP;
        end
      end
      WRITE:   state_d = IDLE;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      off_q     <= 2'b00;
      wdata_q   <= 32'h0;
      rd_q      <= 5'd0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wword_q   <= 32'h0;
      rdata_q   <= 32'h0;
      resp_rd_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wword_q   <= wword_d;
      rdata_q   <= rdata_d;
      resp_rd_q <= resp_rd_d;
    end
  end

  // Strobes decode straight from the state register so an async reset kills a write at once.
  assign req_ready      = (state_q == IDLE);
  assign mem_rw         = (state_q == WRITE);
  assign resp_valid     = (state_q == RESP);
  assign misalign_err   = (state_q == ERR);
  assign resp_data      = rdata_q;
  assign resp_rd        = resp_rd_q;
  assign mem_read_addr  = raddr_q;
  assign mem_write_addr = waddr_q;
  assign mem_write_data = wword_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench with a behavioural data memory
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_rd;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic [4:0]    resp_rd;
  logic          misalign_err;
  logic [AW-1:0] mem_read_addr;
  logic [31:0]   mem_read_data;
  logic [AW-1:0] mem_write_addr;
  logic [31:0]   mem_write_data;
  logic          mem_rw;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;

  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rd         (req_rd),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_rd        (resp_rd),
    .misalign_err   (misalign_err),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .mem_rw         (mem_rw)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_rw) mem[mem_write_addr] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [AW+1:0] a, input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd; req_rd = rd;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_rw"}, {31'h0, mem_rw}, 32'h0);
    chk({tag, "_rvalid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_rdata"}, resp_data, 32'h0);
    chk({tag, "_rrd"}, {27'h0, resp_rd}, 32'h0);
    chk({tag, "_merr"}, {31'h0, misalign_err}, 32'h0);
    chk({tag, "_raddr"}, {23'h0, mem_read_addr}, 32'h0);
    chk({tag, "_waddr"}, {23'h0, mem_write_addr}, 32'h0);
    chk({tag, "_wdata"}, mem_write_data, 32'h0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic sg,
                         input logic [AW+1:0] a, input logic [4:0] rd, input logic [31:0] exp);
    drive(1'b0, sz, sg, a, 32'h0, rd);
    tick();
    chk({tag, "_busy"}, {31'h0, req_ready}, 32'h0);
    chk({tag, "_rd_rw"}, {31'h0, mem_rw}, 32'h0);
    chk({tag, "_raddr"}, {23'h0, mem_read_addr}, {23'h0, a[AW+1:2]});
    chk({tag, "_novalid"}, {31'h0, resp_valid}, 32'h0);
    req_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_rd"}, {27'h0, resp_rd}, {27'h0, rd});
    tick();
    chk({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_idle"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_hold"}, resp_data, exp);
  endtask

  task automatic do_sub_store(input string tag, input logic [1:0] sz, input logic [AW+1:0] a,
                              input logic [31:0] wd, input logic [31:0] exp);
    drive(1'b1, sz, 1'b0, a, wd, 5'd0);
    tick();
    req_valid = 1'b0;
    chk({tag, "_rd_rw"}, {31'h0, mem_rw}, 32'h0);
    chk({tag, "_raddr"}, {23'h0, mem_read_addr}, {23'h0, a[AW+1:2]});
    tick();
    chk({tag, "_wr_rw"}, {31'h0, mem_rw}, 32'h1);
    chk({tag, "_waddr"}, {23'h0, mem_write_addr}, {23'h0, a[AW+1:2]});
    chk({tag, "_wdata"}, mem_write_data, exp);
    chk({tag, "_noresp"}, {31'h0, resp_valid}, 32'h0);
    tick();
    chk({tag, "_rw_off"}, {31'h0, mem_rw}, 32'h0);
    chk({tag, "_idle"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_noresp2"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_mem"}, mem[a[AW+1:2]], exp);
  endtask

  task automatic do_misalign(input string tag, input logic w, input logic [1:0] sz,
                             input logic [AW+1:0] a);
    drive(w, sz, 1'b0, a, 32'hFFFF_FFFF, 5'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_merr"}, {31'h0, misalign_err}, 32'h1);
    chk({tag, "_novalid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_rw"}, {31'h0, mem_rw}, 32'h0);
    chk({tag, "_busy"}, {31'h0, req_ready}, 32'h0);
    tick();
    chk({tag, "_merr_off"}, {31'h0, misalign_err}, 32'h0);
    chk({tag, "_idle"}, {31'h0, req_ready}, 32'h1);
    chk({tag, "_rw2"}, {31'h0, mem_rw}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'h0; req_rd = 5'd0;
    pl_en = 1'b0; pl_addr = '0; pl_data = 32'h0;
    #1;
    preload(9'd0,   32'h0000_0000);
    preload(9'd3,   32'h0000_0000);
    preload(9'd5,   32'h1234_80FF);
    preload(9'd7,   32'hAABB_CCDD);
    preload(9'd9,   32'h0102_0304);
    preload(9'd511, 32'h89AB_CDEF);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Loads: lanes, extension, size 11 as word, top-of-memory index
    do_load("ld_b_s",   SZ_BYTE, 1'b1, 11'h015, 5'd7,  32'hFFFF_FF80);
    do_load("ld_h_u",   SZ_HALF, 1'b0, 11'h016, 5'd9,  32'h0000_1234);
    do_load("ld_b_u",   SZ_BYTE, 1'b0, 11'h014, 5'd2,  32'h0000_00FF);
    do_load("ld_h_s",   SZ_HALF, 1'b1, 11'h014, 5'd31, 32'hFFFF_80FF);
    do_load("ld_sz3",   2'b11,   1'b1, 11'h014, 5'd4,  32'h1234_80FF);
    do_load("ld_w_top", SZ_WORD, 1'b1, 11'h7FC, 5'd5,  32'h89AB_CDEF);
    do_load("ld_b_top", SZ_BYTE, 1'b1, 11'h7FF, 5'd6,  32'hFFFF_FF89);

    // Sub-word stores: read-modify-write, upper store bits ignored
    do_sub_store("st_b", SZ_BYTE, 11'h01E, 32'hCAFE_0011, 32'hAA11_CCDD);
    do_sub_store("st_h", SZ_HALF, 11'h01C, 32'h1234_BEEF, 32'hAA11_BEEF);
    do_sub_store("st_b3", SZ_BYTE, 11'h01F, 32'h0000_0077, 32'h7711_BEEF);

    // Misaligned requests are dropped
    do_misalign("mis_w_ld", 1'b0, SZ_WORD, 11'h002);
    do_misalign("mis_h_st", 1'b1, SZ_HALF, 11'h001);
    chk("mis_h_st_mem", mem[0], 32'h0000_0000);
    do_misalign("mis_3_st", 1'b1, 2'b11, 11'h003);

    // Back-to-back with req_valid held: word store then word load
    drive(1'b1, SZ_WORD, 1'b0, 11'h00C, 32'hDEAD_BEEF, 5'd0);
    tick();
    chk("b2b_wr_rw", {31'h0, mem_rw}, 32'h1);
    chk("b2b_wr_busy", {31'h0, req_ready}, 32'h0);
    chk("b2b_wr_addr", {23'h0, mem_write_addr}, 32'd3);
    chk("b2b_wr_data", mem_write_data, 32'hDEAD_BEEF);
    drive(1'b0, SZ_WORD, 1'b0, 11'h00C, 32'h0, 5'd12);
    tick();
    chk("b2b_ready", {31'h0, req_ready}, 32'h1);
    chk("b2b_mem", mem[3], 32'hDEAD_BEEF);
    chk("b2b_rw_off", {31'h0, mem_rw}, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("b2b_rd_busy", {31'h0, req_ready}, 32'h0);
    chk("b2b_rd_rw", {31'h0, mem_rw}, 32'h0);
    tick();
    chk("b2b_valid", {31'h0, resp_valid}, 32'h1);
    chk("b2b_data", resp_data, 32'hDEAD_BEEF);
    chk("b2b_rd", {27'h0, resp_rd}, 32'd12);
    tick();
    chk("b2b_idle", {31'h0, req_ready}, 32'h1);

    // Reset during the WRITE of a sub-word store
    drive(1'b1, SZ_BYTE, 1'b0, 11'h025, 32'h0000_0055, 5'd0);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstw_rw", {31'h0, mem_rw}, 32'h1);
    chk("rstw_wdata", mem_write_data, 32'h0102_5504);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rstw");
    tick();
    chk("rstw_mem", mem[9], 32'h0102_0304);
    chk("rstw_rw2", {31'h0, mem_rw}, 32'h0);
    rst = 1'b0;
    tick();
    do_load("rstw_ld", SZ_BYTE, 1'b0, 11'h025, 5'd3, 32'h0000_0003);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
